// File: rtl/wb_everloop_fb_if.sv
// Wishbone bus bundle for the everloop feedback decoder.
// The master drives strobe/cycle/address/data; the slave returns ack and read data.
interface wb_everloop_fb_if;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;

    modport master (
        output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_ack_o, wb_dat_o
    );

    modport slave (
        input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_ack_o, wb_dat_o
    );
endinterface

// File: rtl/wb_everloop_fb.sv
// Decodes the WS2812-style stream returned from the LED chain into a byte buffer
// with frame status, readable over Wishbone.
module wb_everloop_fb #(
    parameter int unsigned adr_width    = 8,
    parameter int unsigned BIT_THRESH   = 90,
    parameter int unsigned MIN_HIGH     = 15,
    parameter int unsigned MAX_HIGH     = 225,
    parameter int unsigned RESET_CYCLES = 7500
) (
    input  logic              clk,
    input  logic              reset,
    wb_everloop_fb_if.slave   wb,
    input  logic              led_fb
);
    localparam logic [15:0] THRESH_C = 16'(BIT_THRESH);
    localparam logic [15:0] MIN_C    = 16'(MIN_HIGH);
    localparam logic [15:0] MAX_C    = 16'(MAX_HIGH);
    localparam logic [15:0] RESET_C  = 16'(RESET_CYCLES);
    localparam int unsigned DEPTH    = 2 ** adr_width;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP  = 3'd1,
        ST_HIGH = 3'd2,
        ST_LOW  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic                 sync1_r, sync2_r, sync3_r;
    logic                 line_s, rise_s, fall_s;
    state_t               state_r, state_s;
    logic [15:0]          cnt_r, cnt_s;
    logic                 bit_valid_s, bit_val_s, glitch_s, stuck_s, frame_end_s;
    logic [2:0]           bitcnt_r;
    logic [6:0]           sh_r;
    logic [adr_width:0]   ptr_r, bytes_r;
    logic [15:0]          frames_r;
    logic                 valid_r, ovf_r, partial_r, perr_r;
    logic                 en_r, oneshot_r;
    logic                 ack_r;
    logic [31:0]          dat_r, rdata_s;
    logic                 req_s, wr_s, map_ok_s, wr_ctrl_s, wr_stat_s, wr_frames_s;
    logic                 byte_done_s, mem_we_s;
    logic [7:0]           mem_r [DEPTH];

    assign line_s = sync2_r;
    assign rise_s = sync2_r & ~sync3_r;
    assign fall_s = ~sync2_r & sync3_r;

    // Two-stage synchronizer for led_fb plus one delay stage for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= led_fb;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Decoder state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Decoder next-state logic; IDLE and ERR only release after a full reset gap
    always_comb begin
        state_s = state_r;
        if (!en_r) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_ERR: begin
                    if (!line_s && cnt_r >= RESET_C) state_s = ST_GAP;
                    else                             state_s = state_r;
                end
                ST_GAP: begin
                    if (rise_s) state_s = ST_HIGH;
                    else        state_s = ST_GAP;
                end
                ST_HIGH: begin
                    if (fall_s)             state_s = ST_LOW;
                    else if (cnt_r > MAX_C) state_s = ST_ERR;
                    else                    state_s = ST_HIGH;
                end
                ST_LOW: begin
                    if (rise_s)                  state_s = ST_HIGH;
                    else if (cnt_r >= RESET_C)   state_s = ST_GAP;
                    else                         state_s = ST_LOW;
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Decoder outputs: level-duration counter and bit/glitch/stuck/frame events
    always_comb begin
        cnt_s       = 16'd0;
        bit_valid_s = 1'b0;
        bit_val_s   = 1'b0;
        glitch_s    = 1'b0;
        stuck_s     = 1'b0;
        frame_end_s = 1'b0;
        if (en_r) begin
            case (state_r)
                ST_IDLE, ST_ERR: begin
                    if (line_s) cnt_s = 16'd0;
                    else        cnt_s = sat_inc(cnt_r);
                end
                ST_GAP: begin
                    if (rise_s) cnt_s = 16'd1;
                    else        cnt_s = 16'd0;
                end
                ST_HIGH: begin
                    if (fall_s) begin
                        cnt_s = 16'd1;
                        if (cnt_r < MIN_C) begin
                            glitch_s = 1'b1;
                        end else begin
                            bit_valid_s = 1'b1;
                            bit_val_s   = (cnt_r >= THRESH_C);
                        end
                    end else begin
                        cnt_s   = sat_inc(cnt_r);
                        stuck_s = (cnt_r > MAX_C);
                    end
                end
                ST_LOW: begin
                    if (rise_s) begin
                        cnt_s = 16'd1;
                    end else begin
                        cnt_s       = sat_inc(cnt_r);
                        frame_end_s = (cnt_r >= RESET_C) &&
                                      (ptr_r != '0 || bitcnt_r != 3'd0);
                    end
                end
                default: cnt_s = 16'd0;
            endcase
        end else begin
            cnt_s = 16'd0;
        end
    end

    assign byte_done_s = bit_valid_s && (bitcnt_r == 3'd7);
    assign mem_we_s    = byte_done_s && !ptr_r[adr_width];

    assign req_s       = wb.wb_stb_i & wb.wb_cyc_i & ~ack_r;
    assign wr_s        = req_s & wb.wb_we_i;
    assign map_ok_s    = (wb.wb_adr_i[31:11] == 21'd0) && !wb.wb_adr_i[10];
    assign wr_ctrl_s   = wr_s && map_ok_s && (wb.wb_adr_i[9:0] == 10'd0);
    assign wr_stat_s   = wr_s && map_ok_s && (wb.wb_adr_i[9:0] == 10'd1);
    assign wr_frames_s = wr_s && map_ok_s && (wb.wb_adr_i[9:0] == 10'd2);

    // Bit shifting, byte pointer and frame bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitcnt_r <= 3'd0;
            sh_r     <= 7'd0;
            ptr_r    <= '0;
            bytes_r  <= '0;
        end else if (!en_r || stuck_s) begin
            bitcnt_r <= 3'd0;
            ptr_r    <= '0;
        end else if (frame_end_s) begin
            bytes_r  <= ptr_r;
            ptr_r    <= '0;
            bitcnt_r <= 3'd0;
        end else if (bit_valid_s) begin
            sh_r     <= {sh_r[5:0], bit_val_s};
            bitcnt_r <= bitcnt_r + 3'd1;
            if (mem_we_s) ptr_r <= ptr_r + 1'b1;
            else          ptr_r <= ptr_r;
        end else begin
            bitcnt_r <= bitcnt_r;
        end
    end

    // Control, sticky status flags (set beats clear) and frame counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_r      <= 1'b0;
            oneshot_r <= 1'b0;
            valid_r   <= 1'b0;
            ovf_r     <= 1'b0;
            partial_r <= 1'b0;
            perr_r    <= 1'b0;
            frames_r  <= 16'd0;
        end else begin
            if (wr_ctrl_s) begin
                en_r      <= wb.wb_dat_i[0];
                oneshot_r <= wb.wb_dat_i[1];
            end else if (frame_end_s && oneshot_r) begin
                en_r <= 1'b0;
            end else begin
                en_r <= en_r;
            end
            valid_r   <= frame_end_s | (valid_r & ~(wr_stat_s & wb.wb_dat_i[0]));
            ovf_r     <= (byte_done_s & ptr_r[adr_width]) |
                         (ovf_r & ~(wr_stat_s & wb.wb_dat_i[1]));
            partial_r <= (frame_end_s & (bitcnt_r != 3'd0)) |
                         (partial_r & ~(wr_stat_s & wb.wb_dat_i[2]));
            perr_r    <= glitch_s | stuck_s | (perr_r & ~(wr_stat_s & wb.wb_dat_i[3]));
            if (frame_end_s)      frames_r <= frames_r + 16'd1;
            else if (wr_frames_s) frames_r <= 16'd0;
            else                  frames_r <= frames_r;
        end
    end

    // Byte buffer write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s) mem_r[ptr_r[adr_width-1:0]] <= {sh_r, bit_val_s};
    end

    // Read data selection; the buffer path becomes a synchronous read through dat_r
    always_comb begin
        rdata_s = 32'd0;
        if (wb.wb_adr_i[31:11] != 21'd0) begin
            rdata_s = 32'd0;
        end else if (wb.wb_adr_i[10]) begin
            rdata_s = {24'd0, mem_r[wb.wb_adr_i[adr_width-1:0]]};
        end else begin
            case (wb.wb_adr_i[9:0])
                10'd0:   rdata_s = {30'd0, oneshot_r, en_r};
                10'd1:   rdata_s = {16'(bytes_r), 12'd0, perr_r, partial_r, ovf_r, valid_r};
                10'd2:   rdata_s = {16'd0, frames_r};
                default: rdata_s = 32'd0;
            endcase
        end
    end

    // Single-cycle ack and registered read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_r <= 1'b0;
            dat_r <= 32'd0;
        end else begin
            ack_r <= req_s;
            if (req_s) dat_r <= rdata_s;
            else       dat_r <= dat_r;
        end
    end

    assign wb.wb_ack_o = wb.wb_stb_i & wb.wb_cyc_i & ack_r;
    assign wb.wb_dat_o = dat_r;
endmodule

// File: tb/tb_wb_everloop_fb.sv
// Directed and randomized checks of wb_everloop_fb against a frame-level reference model.
module tb_wb_everloop_fb;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int T1H = 24, T1L = 6, T0H = 9, T0L = 21, GAPCY = 1600;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic led_fb = 1'b0;
    wb_everloop_fb_if wb();

    always #5 clk = ~clk;

    wb_everloop_fb #(
        .adr_width(AW), .BIT_THRESH(18), .MIN_HIGH(3), .MAX_HIGH(45), .RESET_CYCLES(1500)
    ) dut (
        .clk(clk), .reset(reset), .wb(wb), .led_fb(led_fb)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem_m [DEPTH];
    bit         known_m [DEPTH];
    int         frames_m, bytes_m;
    bit         valid_m, ovf_m, partial_m, perr_m, en_m, os_m;
    logic [31:0] rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                            output logic [31:0] rdat);
        bit got = 1'b0;
        rdat = 32'hX;
        @(negedge clk);
        wb.wb_stb_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_we_i = we;
        wb.wb_adr_i = adr;  wb.wb_dat_i = wdat;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (wb.wb_ack_o) begin
                got  = 1'b1;
                rdat = wb.wb_dat_o;
            end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $error("FAIL ack_timeout adr=%h observed=no-ack expected=ack", adr);
        end
        @(negedge clk);
        wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_cycle(1'b1, adr, wdat, dummy);
    endtask

    task automatic hold(input logic v, input int n);
        led_fb = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        hold(1'b1, b ? T1H : T0H);
        hold(1'b0, b ? T1L : T0L);
    endtask

    // Reference model: what the chain should have captured for a frame of nbits bits
    task automatic model_frame(input logic [7:0] data[$], input int nbits);
        int nb;
        if (!en_m || nbits == 0) return;
        nb = nbits / 8;
        for (int i = 0; i < nb && i < DEPTH; i++) begin
            mem_m[i]   = data[i];
            known_m[i] = 1'b1;
        end
        bytes_m   = (nb > DEPTH) ? DEPTH : nb;
        ovf_m     = ovf_m | (nb > DEPTH);
        partial_m = partial_m | ((nbits % 8) != 0);
        valid_m   = 1'b1;
        frames_m  = (frames_m + 1) % 65536;
        if (os_m) en_m = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] data[$], input int nbits);
        logic [7:0] cur;
        for (int i = 0; i < nbits; i++) begin
            cur = data[i / 8];
            send_bit(cur[7 - (i % 8)]);
        end
        hold(1'b0, GAPCY);
        model_frame(data, nbits);
    endtask

    task automatic check_all(input string tag);
        logic [31:0] r;
        wb_cycle(1'b0, 32'h000, 32'd0, r);
        chk({tag, "_ctrl"}, r, {30'd0, os_m, en_m});
        wb_cycle(1'b0, 32'h001, 32'd0, r);
        chk({tag, "_status"}, r, {16'(bytes_m), 12'd0, perr_m, partial_m, ovf_m, valid_m});
        wb_cycle(1'b0, 32'h002, 32'd0, r);
        chk({tag, "_frames"}, r, {16'd0, 16'(frames_m)});
        for (int i = 0; i < DEPTH; i++) begin
            if (known_m[i]) begin
                wb_cycle(1'b0, 32'h400 + 32'(i), 32'd0, r);
                chk($sformatf("%s_buf%0d", tag, i), r, {24'd0, mem_m[i]});
            end
        end
    endtask

    task automatic clear_status();
        wb_write(32'h001, 32'hF);
        valid_m = 1'b0; ovf_m = 1'b0; partial_m = 1'b0; perr_m = 1'b0;
    endtask

    task automatic rand_bytes(input int n, output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] qa[$];
        logic [7:0] glitch_byte;

        wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = 32'd0; wb.wb_sel_i = 4'hF; wb.wb_dat_i = 32'd0;
        for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
        frames_m = 0; bytes_m = 0;
        valid_m = 0; ovf_m = 0; partial_m = 0; perr_m = 0; en_m = 0; os_m = 0;

        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        chk("rst_ack", {31'd0, wb.wb_ack_o}, 32'd0);
        chk("rst_dat", wb.wb_dat_o, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        check_all("reset");

        // Basic 24-bit frame
        wb_write(32'h000, 32'd1); en_m = 1'b1;
        hold(1'b0, GAPCY);
        q = {8'hFF, 8'h00, 8'h80};
        send_frame(q, 24);
        check_all("basic");

        // Write-1-to-clear with ack pulse-width check
        @(negedge clk);
        wb.wb_stb_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_we_i = 1'b1;
        wb.wb_adr_i = 32'h001; wb.wb_dat_i = 32'hF;
        @(posedge clk); #1;
        chk("ack_first", {31'd0, wb.wb_ack_o}, 32'd1);
        @(posedge clk); #1;
        chk("ack_drop", {31'd0, wb.wb_ack_o}, 32'd0);
        @(negedge clk);
        wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_we_i = 1'b0;
        valid_m = 1'b0;
        check_all("w1c");

        // Randomized whole-byte frames
        for (int f = 0; f < 3; f++) begin
            rand_bytes(int'($urandom_range(1, 6)), q);
            send_frame(q, q.size() * 8);
            check_all($sformatf("rand%0d", f));
            clear_status();
        end

        // Overflow: more bytes than the buffer holds
        rand_bytes(DEPTH + 2, q);
        send_frame(q, (DEPTH + 2) * 8);
        check_all("ovf");
        clear_status();

        // Partial byte: 20 bits leave buf[2] untouched
        rand_bytes(3, q);
        send_frame(q, 20);
        check_all("partial");
        clear_status();

        // One-cycle glitch inside the low phase of a zero bit
        glitch_byte = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                hold(1'b1, T0H); hold(1'b0, 10); hold(1'b1, 1); hold(1'b0, 10);
            end else begin
                send_bit(glitch_byte[7 - i]);
            end
        end
        hold(1'b0, GAPCY);
        q = {glitch_byte};
        model_frame(q, 8);
        perr_m = 1'b1;
        check_all("glitch");
        clear_status();

        // Stuck-high pulse aborts the frame without counting it
        rand_bytes(1, q);
        for (int i = 0; i < 4; i++) send_bit(q[0][7 - i]);
        hold(1'b1, 60);
        hold(1'b0, GAPCY);
        perr_m = 1'b1;
        check_all("stuck");
        rand_bytes(2, q);
        send_frame(q, 16);
        check_all("after_stuck");
        clear_status();

        // One-shot: only the first of two frames lands
        wb_write(32'h000, 32'd3); os_m = 1'b1; en_m = 1'b1;
        rand_bytes(2, qa);
        send_frame(qa, 16);
        rand_bytes(3, q);
        send_frame(q, 24);
        check_all("oneshot");

        // Reset in the middle of a byte
        wb_write(32'h000, 32'd1); os_m = 1'b0; en_m = 1'b1;
        hold(1'b0, GAPCY);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        led_fb = 1'b1;
        wb_cycle(1'b0, 32'h001, 32'd0, rd);
        chk("pre_rst_status", rd, {16'(bytes_m), 12'd0, perr_m, partial_m, ovf_m, valid_m});
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ack", {31'd0, wb.wb_ack_o}, 32'd0);
        chk("midrst_dat", wb.wb_dat_o, 32'd0);
        @(negedge clk);
        led_fb = 1'b0;
        reset = 1'b1;
        frames_m = 0; bytes_m = 0;
        valid_m = 0; ovf_m = 0; partial_m = 0; perr_m = 0; en_m = 0; os_m = 0;
        check_all("midrst");

        // After reset the decoder must see a full gap before locking
        wb_write(32'h000, 32'd1);
        rand_bytes(1, q);
        for (int i = 0; i < 8; i++) send_bit(q[0][7 - i]);
        hold(1'b0, GAPCY);
        en_m = 1'b1;
        check_all("idle_lock");
        rand_bytes(2, q);
        send_frame(q, 16);
        check_all("relock");

        // Any write to FRAMES clears it
        wb_write(32'h002, 32'h1234);
        frames_m = 0;
        check_all("frames_clr");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
